// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared states, slot layout and constants for the RTC alarm scheduler
package rtc_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int KEY_LSB    = 15;
  localparam int KEY_W      = 32 - KEY_LSB;
  localparam int ARMED_BIT  = 14;
  localparam int REPEAT_BIT = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Field order reproduces the register layout: key, armed (bit 14), repeat (bit 13), zeros
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             armed;
    logic             rpt;
    logic [12:0]      zero;
  } alarm_t;

endpackage

// File: rtl/rtc_alarm_slot_alloc.sv
// rtl/rtc_alarm_slot_alloc.sv - lowest-free-slot finder and armed duplicate-key detector
module rtc_alarm_slot_alloc
  import rtc_pkg::*;
(
  input  alarm_t [NUM_SLOTS-1:0] slots,
  input  logic   [KEY_W-1:0]     key,
  output logic   [1:0]           free_idx,
  output logic                   dup
);

  always_comb begin
    free_idx = 2'd0;
    dup      = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].armed) free_idx = 2'(i);
    end
    // Only armed slots count; a disarmed slot keeps its stale key
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots[i].armed && (slots[i].key == key)) dup = 1'b1;
    end
  end

endmodule

// File: rtl/rtc_alarm_scheduler.sv
// rtl/rtc_alarm_scheduler.sv - alarm slots, tick-driven scan and prioritised irq
// Repeating alarms (add_repeat port, slot bit 13) exist only when RTC_ALARM_REPEAT_EN is defined.
module rtc_alarm_scheduler
  import rtc_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic   [31:0]          curr_time,
  input  logic                   add_valid,
  input  logic   [31:0]          add_time,
`ifdef RTC_ALARM_REPEAT_EN
  input  logic                   add_repeat,
`endif
  output logic                   add_ready,
  output logic                   add_dup,
  input  logic                   clr_valid,
  input  logic   [1:0]           clr_idx,
  input  logic                   irq_ack,
  output alarm_t [NUM_SLOTS-1:0] alarm,
  output logic                   full,
  output logic                   irq,
  output logic   [1:0]           irq_idx,
  output logic                   tick_overrun
);

  state_t                 state, state_n;
  logic   [1:0]           idx, idx_n;
  logic                   tick_lat, tick_lat_n;
  logic                   scan_start, overrun_n;
  logic   [KEY_W-1:0]     key_snap;
  logic   [NUM_SLOTS-1:0] pending, pending_n;
  alarm_t [NUM_SLOTS-1:0] alarm_n;
  logic                   dup_n, full_n, irq_n;
  logic   [1:0]           irq_idx_n;
  logic   [1:0]           free_idx;
  logic                   key_dup, add_fire, match, new_rpt;
  logic                   unused_low;

  assign unused_low = ^{curr_time[KEY_LSB-1:0], add_time[KEY_LSB-1:0]};

`ifdef RTC_ALARM_REPEAT_EN
  assign new_rpt = add_repeat;
`else
  assign new_rpt = 1'b0;
`endif

  rtc_alarm_slot_alloc u_alloc (
    .slots    (alarm),
    .key      (add_time[31:KEY_LSB]),
    .free_idx (free_idx),
    .dup      (key_dup)
  );

  assign add_ready = (state == IDLE) && !full && !tick && !tick_lat;
  assign add_fire  = add_valid && add_ready;
  assign match     = (state == SCAN) && alarm[idx].armed && (alarm[idx].key == key_snap);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tick_lat_n = tick_lat;
    scan_start = 1'b0;
    overrun_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tick || tick_lat) begin
          state_n    = SCAN;
          idx_n      = 2'd0;
          tick_lat_n = 1'b0;
          scan_start = 1'b1;
        end
      end
      SCAN: begin
        if (idx == 2'd3) begin
          // Back-to-back scan: a pending latch is consumed and a fresh tick takes its place
          if (tick_lat || tick) begin
            idx_n      = 2'd0;
            scan_start = 1'b1;
            tick_lat_n = tick_lat && tick;
          end else begin
            state_n = IDLE;
          end
        end else begin
          idx_n = idx + 2'd1;
          if (tick) begin
            if (tick_lat) overrun_n = 1'b1;
            else          tick_lat_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    alarm_n   = alarm;
    pending_n = pending;
    dup_n     = 1'b0;
    if (add_fire) begin
      if (key_dup) dup_n = 1'b1;
      else alarm_n[free_idx] = '{key: add_time[31:KEY_LSB], armed: 1'b1, rpt: new_rpt, zero: '0};
    end
    if (irq && irq_ack) pending_n[irq_idx] = 1'b0;
    if (match) begin
      pending_n[idx] = 1'b1;
      if (!alarm[idx].rpt) alarm_n[idx].armed = 1'b0;
    end
    // Applied last so a clear beats a same-cycle match on its slot
    if (clr_valid) begin
      alarm_n[clr_idx].armed = 1'b0;
      pending_n[clr_idx]     = 1'b0;
    end
    full_n    = 1'b1;
    irq_idx_n = 2'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!alarm_n[i].armed) full_n = 1'b0;
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending_n[i]) irq_idx_n = 2'(i);
    end
    irq_n = |pending_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      tick_lat     <= 1'b0;
      key_snap     <= '0;
      pending      <= '0;
      alarm        <= '0;
      full         <= 1'b0;
      irq          <= 1'b0;
      irq_idx      <= 2'd0;
      add_dup      <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      tick_lat     <= tick_lat_n;
      if (scan_start) key_snap <= curr_time[31:KEY_LSB];
      pending      <= pending_n;
      alarm        <= alarm_n;
      full         <= full_n;
      irq          <= irq_n;
      irq_idx      <= irq_idx_n;
      add_dup      <= dup_n;
      tick_overrun <= overrun_n;
    end
  end

endmodule

// File: tb/tb_rtc_alarm_scheduler.sv
// tb/tb_rtc_alarm_scheduler.sv - directed table and sequence bench for rtc_alarm_scheduler
module tb_rtc_alarm_scheduler;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic [31:0]      curr_time;
  logic             add_valid;
  logic [31:0]      add_time;
`ifdef RTC_ALARM_REPEAT_EN
  logic             add_repeat;
`endif
  logic             add_ready;
  logic             add_dup;
  logic             clr_valid;
  logic [1:0]       clr_idx;
  logic             irq_ack;
  logic [3:0][31:0] alarm;
  logic             full;
  logic             irq;
  logic [1:0]       irq_idx;
  logic             tick_overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        add_v;
    logic [31:0] add_t;
    logic        clr_v;
    logic [1:0]  clr_i;
    int          slot;
    logic [31:0] exp_slot;
    logic        exp_full;
    logic        exp_dup;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  rtc_alarm_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .curr_time    (curr_time),
    .add_valid    (add_valid),
    .add_time     (add_time),
`ifdef RTC_ALARM_REPEAT_EN
    .add_repeat   (add_repeat),
`endif
    .add_ready    (add_ready),
    .add_dup      (add_dup),
    .clr_valid    (clr_valid),
    .clr_idx      (clr_idx),
    .irq_ack      (irq_ack),
    .alarm        (alarm),
    .full         (full),
    .irq          (irq),
    .irq_idx      (irq_idx),
    .tick_overrun (tick_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] t);
    add_valid = 1'b1;
    add_time  = t;
    step();
    add_valid = 1'b0;
  endtask

  task automatic clr(input logic [1:0] i);
    clr_valid = 1'b1;
    clr_idx   = i;
    step();
    clr_valid = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0001_8000, 1'b0, 2'd0, 0, 32'h0001_C000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h0001_8000, 1'b0, 2'd0, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 32'h0000_0000, 1'b0, 2'd0, 0, 32'h0001_C000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'h0002_0000, 1'b0, 2'd0, 1, 32'h0002_4000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'h0003_0000, 1'b0, 2'd0, 2, 32'h0003_4000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'h0004_0000, 1'b0, 2'd0, 3, 32'h0004_4000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0005_0000, 1'b0, 2'd0, 3, 32'h0004_4000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 1'b1, 2'd2, 2, 32'h0003_0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0005_0000, 1'b0, 2'd0, 2, 32'h0005_4000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 2'd0, 0, 32'h0001_8000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 2'd1, 1, 32'h0002_0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 2'd2, 2, 32'h0005_0000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0000, 1'b1, 2'd3, 3, 32'h0004_0000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'h0001_8FFF, 1'b0, 2'd0, 0, 32'h0001_C000, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_0000, 1'b1, 2'd0, 0, 32'h0001_8000, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; tick = 1'b0; curr_time = '0; add_valid = 1'b0; add_time = '0;
    clr_valid = 1'b0; clr_idx = '0; irq_ack = 1'b0;
`ifdef RTC_ALARM_REPEAT_EN
    add_repeat = 1'b0;
`endif
    step(); step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("reset_alarm%0d", i), alarm[i], 32'h0);
    chk("reset_full", full, 0);
    chk("reset_irq", irq, 0);
    chk("reset_irq_idx", irq_idx, 0);
    chk("reset_ready", add_ready, 1);
    chk("reset_dup", add_dup, 0);
    chk("reset_overrun", tick_overrun, 0);

    for (int i = 0; i < 15; i++) begin
      add_valid = vecs[i].add_v;
      add_time  = vecs[i].add_t;
      clr_valid = vecs[i].clr_v;
      clr_idx   = vecs[i].clr_i;
      step();
      add_valid = 1'b0;
      clr_valid = 1'b0;
      chk($sformatf("vec%0d_alarm%0d", i, vecs[i].slot), alarm[vecs[i].slot], vecs[i].exp_slot);
      chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      chk($sformatf("vec%0d_dup", i), add_dup, vecs[i].exp_dup);
      chk($sformatf("vec%0d_ready", i), add_ready, vecs[i].exp_ready);
    end

    // Priority: slot 3 fires on one tick, slot 0 on the next
    add(32'h1234_0000); add(32'h0100_0000); add(32'h0200_0000); add(32'h5678_0000);
    chk("prio_full", full, 1);
    curr_time = 32'h5678_7ABC;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("prio_irq_n%0d", c), irq, (c == 5));
      if (c < 5) chk($sformatf("prio_ready_n%0d", c), add_ready, 0);
      if (c < 5) step();
    end
    chk("prio_idx3", irq_idx, 3);
    chk("prio_slot3_disarmed", alarm[3], 32'h5678_0000);
    chk("prio_full_after", full, 0);
    curr_time = 32'h1234_5678;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("prio_idx_m1", irq_idx, 3);
    step();
    chk("prio_idx_m2", irq_idx, 0);
    step(); step(); step();
    chk("prio_slot0_disarmed", alarm[0], 32'h1234_0000);
    ack();
    chk("ack1_irq", irq, 1);
    chk("ack1_idx", irq_idx, 3);
    ack();
    chk("ack2_irq", irq, 0);
    ack();
    chk("ack3_irq", irq, 0);
    chk("ack3_idx", irq_idx, 0);

    // Overrun: ticks at N, N+1, N+2; second scan matches slot 1 with a later snapshot
    curr_time = 32'h0000_0000;
    tick = 1'b1;
    step();
    step();
    chk("ovr_n2", tick_overrun, 0);
    step();
    tick = 1'b0;
    chk("ovr_n3", tick_overrun, 1);
    chk("ovr_ready_n3", add_ready, 0);
    curr_time = 32'h0100_1234;
    step();
    chk("ovr_n4", tick_overrun, 0);
    step();
    chk("ovr_ready_n5", add_ready, 0);
    chk("ovr_irq_n5", irq, 0);
    step();
    chk("ovr_irq_n6", irq, 0);
    step();
    chk("ovr_irq_n7", irq, 1);
    chk("ovr_idx_n7", irq_idx, 1);
    step();
    chk("ovr_ready_n8", add_ready, 0);
    step();
    chk("ovr_ready_n9", add_ready, 1);
    ack();
    chk("ovr_ack", irq, 0);

    // Clear lands in the exact cycle slot 1 is compared
    clr(2'd2);
    add(32'h0700_0000);
    add(32'h0800_0000);
    chk("clrm_armed", alarm[1], 32'h0800_4000);
    curr_time = 32'h0800_0000;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    clr_valid = 1'b1;
    clr_idx   = 2'd1;
    step();
    clr_valid = 1'b0;
    chk("clrm_irq", irq, 0);
    chk("clrm_slot1", alarm[1], 32'h0800_0000);
    step(); step();
    chk("clrm_irq_end", irq, 0);
    chk("clrm_ready_end", add_ready, 1);

`ifdef RTC_ALARM_REPEAT_EN
    add_repeat = 1'b1;
    add(32'h0900_0000);
    add_repeat = 1'b0;
    chk("rpt_added", alarm[1], 32'h0900_6000);
    curr_time = 32'h0900_0000;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step(); step(); step();
    chk("rpt_armed", alarm[1], 32'h0900_6000);
    chk("rpt_irq", irq, 1);
    chk("rpt_idx", irq_idx, 1);
    ack();
`endif

    // Reset mid-scan returns to idle with everything cleared
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_scan_ready", add_ready, 1);
    chk("rst_scan_alarm0", alarm[0], 32'h0);
    chk("rst_scan_irq", irq, 0);
    chk("rst_scan_full", full, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
